uart_transmitter_controller: RTL

//  Return path of the system controller. Collects register-file read data and ALU results,

---
 rtl/uart_tx_ctrl_pkg.sv | 22 ++
 rtl/uart_transmitter_controller_slot.sv | 43 ++++
 rtl/uart_transmitter_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and sizing helpers for the UART return-path controller.
// Default widths describe the standard 16-bit ALU / 8-bit byte configuration.
package uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_HI = 2'b01,
    WAIT_LO = 2'b10
  } tx_state_e;

  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_ALU_RESULT_WIDTH = 16;
  localparam int BYTES_PER_RESULT     = DEF_ALU_RESULT_WIDTH / DEF_DATA_WIDTH;

  // A one-byte frame still needs a 1-bit index so the mux stays well formed.
  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int BYTE_IDX_W = idx_width(BYTES_PER_RESULT);

endpackage

// File: rtl/uart_transmitter_controller_slot.sv
// One-entry hold register with full flag for a single data source.
// A capture on the same edge as a clear is accepted, so only a truly full slot overruns.
module tx_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             overrun_set
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) full_d = 1'b0;
    if (valid_in && (!full_q || clr)) begin
      full_d = 1'b1;
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full        = full_q;
  assign data        = data_q;
  assign overrun_set = valid_in && full_q && !clr;

endmodule

// File: rtl/uart_transmitter_controller.sv
// Return-path controller: arbitrates register reads and ALU results into bytes for UART TX.
// Handshake: tx_data_valid is a level held until tx_busy_sync is sampled high (or the wait times
// out); the next byte is offered only after tx_busy_sync is sampled low again.
module uart_transmitter_controller
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ALU_RESULT_WIDTH = 16,
  parameter int BUSY_TIMEOUT     = 1023
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  input  logic                        rd_data_valid,
  input  logic [ALU_RESULT_WIDTH-1:0] alu_out,
  input  logic                        alu_out_valid,
  input  logic                        tx_busy_sync,
  input  logic                        overrun_clr,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_data_valid,
  output logic                        tx_timeout,
  output logic                        overrun
);

  localparam int N_BYTES = ALU_RESULT_WIDTH / DATA_WIDTH;
  localparam int IDX_W   = idx_width(N_BYTES);
  localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic                        rd_full, alu_full, rd_clr, alu_clr, rd_ovr, alu_ovr;
  logic [DATA_WIDTH-1:0]       rd_slot_data;
  logic [ALU_RESULT_WIDTH-1:0] alu_slot_data;
  logic [DATA_WIDTH-1:0]       alu_bytes [N_BYTES];

  tx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  src_alu_q, src_alu_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_timeout_q, tx_timeout_d;
  logic                  overrun_q, overrun_d;

  tx_hold_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
    .clk(clk), .reset_n(reset_n), .valid_in(rd_data_valid), .data_in(rd_data),
    .clr(rd_clr), .full(rd_full), .data(rd_slot_data), .overrun_set(rd_ovr)
  );

  tx_hold_slot #(.WIDTH(ALU_RESULT_WIDTH)) u_alu_slot (
    .clk(clk), .reset_n(reset_n), .valid_in(alu_out_valid), .data_in(alu_out),
    .clr(alu_clr), .full(alu_full), .data(alu_slot_data), .overrun_set(alu_ovr)
  );

  for (genvar g = 0; g < N_BYTES; g++) begin : g_bytes
    assign alu_bytes[g] = alu_slot_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    src_alu_d    = src_alu_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_timeout_d = 1'b0;
    rd_clr       = 1'b0;
    alu_clr      = 1'b0;
    overrun_d    = overrun_clr ? 1'b0 : (overrun_q || rd_ovr || alu_ovr);
    case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (rd_full) begin
          tx_data_d  = rd_slot_data;
          tx_valid_d = 1'b1;
          src_alu_d  = 1'b0;
          rd_clr     = 1'b1;
          state_d    = WAIT_HI;
        end else if (alu_full) begin
          tx_data_d  = alu_bytes[0];
          tx_valid_d = 1'b1;
          src_alu_d  = 1'b1;
          alu_clr    = (N_BYTES == 1);
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy_sync) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          // The ALU slot is still held only if its last byte was never loaded.
          tx_valid_d   = 1'b0;
          tx_timeout_d = 1'b1;
          alu_clr      = src_alu_q && (idx_q != LAST_IDX);
          idx_d        = '0;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_sync) begin
          if (src_alu_q && (idx_q != LAST_IDX)) begin
            tx_data_d  = alu_bytes[idx_nxt];
            tx_valid_d = 1'b1;
            idx_d      = idx_nxt;
            cnt_d      = '0;
            alu_clr    = (idx_nxt == LAST_IDX);
            state_d    = WAIT_HI;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      src_alu_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      src_alu_q    <= src_alu_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_timeout_q <= tx_timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign tx_timeout    = tx_timeout_q;
  assign overrun       = overrun_q;

endmodule
